// File: rtl/io_input_pkg.sv
// Shared word size, EOF value and read-mux selector for the subleq input port.
package io_input_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] IO_EOF = {WORD_SIZE{1'b1}};

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_DATA,
    SEL_EOF
  } in_sel_e;

  function automatic logic [WORD_SIZE-1:0] zero_extend(input logic [7:0] b);
    return {{(WORD_SIZE - 8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/io_input_fifo.sv
// Generic synchronous FIFO; the caller must not push when full or pop when empty.
module io_input_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/io_input.sv
// Input port for the subleq core: buffers source bytes and returns -1 once
// the source has signalled end-of-input and the buffer has drained.
module io_input
  import io_input_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 src_valid,
  input  logic [7:0]           src_data,
  output logic                 src_ready,
  input  logic                 src_eof,
  input  logic                 in_read,
  output logic                 in_wait,
  output logic [WORD_SIZE-1:0] io_in
);

  logic                   push;
  logic                   pop;
  logic [7:0]             head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   eof_seen;
  in_sel_e                sel;

  assign src_ready = ~full;
  assign push      = src_valid & src_ready;
  assign pop       = in_read & (count != '0);

  io_input_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (push),
    .pop   (pop),
    .din   (src_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky end-of-input; buffered bytes still drain before -1 is returned.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      eof_seen <= 1'b0;
    end else if (src_eof) begin
      eof_seen <= 1'b1;
    end
  end

  always_comb begin
    sel = SEL_IDLE;
    if (!empty) begin
      sel = SEL_DATA;
    end else if (eof_seen) begin
      sel = SEL_EOF;
    end
  end

  always_comb begin
    io_in = '0;
    case (sel)
      SEL_DATA: io_in = zero_extend(head);
      SEL_EOF:  io_in = IO_EOF;
      default:  io_in = '0;
    endcase
  end

  assign in_wait = empty & ~eof_seen;

endmodule

// File: tb/tb_io_input.sv
// Scoreboard bench for io_input: the driver queues expected read values and a
// negedge monitor compares every read the DUT accepts.
module tb_io_input;

  localparam int WS = 16;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          src_valid = 1'b0;
  logic [7:0]    src_data = 8'h00;
  logic          src_ready;
  logic          src_eof = 1'b0;
  logic          in_read = 1'b0;
  logic          in_wait;
  logic [WS-1:0] io_in;

  int            n_total = 0;
  int            n_pass = 0;
  logic [WS-1:0] exp_q[$];

  io_input #(.DEPTH(8)) dut (
    .clk      (clk),
    .areset   (areset),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .src_eof  (src_eof),
    .in_read  (in_read),
    .in_wait  (in_wait),
    .io_in    (io_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every accepted read is compared against the head of the queue.
  always @(negedge clk) begin
    if (areset && in_read && !in_wait) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", {16'h0, io_in}, 32'hDEAD_BEEF);
      end else begin
        check("read_data", {16'h0, io_in}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit done = 0;
    src_valid = 1'b1;
    src_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (src_ready) begin
        exp_q.push_back({8'h00, b});
        done = 1;
      end
      step();
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
    src_valid = 1'b0;
  endtask

  task automatic read_one();
    bit done = 0;
    in_read = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!in_wait) done = 1;
      step();
    end
    if (!done) check("read_timeout", 32'd0, 32'd1);
    in_read = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    exp_q.delete();
    #3;
    areset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3 areset = 1'b1;
    step();

    // 1: reset in the middle of a stream
    push_byte(8'h11);
    push_byte(8'h22);
    src_eof = 1'b1;
    step();
    src_eof = 1'b0;
    areset = 1'b0;
    exp_q.delete();
    #2;
    check("rst_count", {28'h0, dut.u_fifo.count}, 32'd0);
    check("rst_src_ready", {31'h0, src_ready}, 32'd1);
    check("rst_in_wait", {31'h0, in_wait}, 32'd1);
    check("rst_io_in", {16'h0, io_in}, 32'd0);
    areset = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_in_wait", {31'h0, in_wait}, 32'd1);
    step();

    // 2: 'H','i'
    push_byte(8'h48);
    push_byte(8'h69);
    read_one();
    read_one();
    @(negedge clk);
    check("hi_in_wait_after", {31'h0, in_wait}, 32'd1);
    step();

    // 3: overfill by one, then pop to let the ninth byte in
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    @(negedge clk);
    check("full_src_ready", {31'h0, src_ready}, 32'd0);
    check("full_count", {28'h0, dut.u_fifo.count}, 32'd8);
    step();
    src_valid = 1'b1;
    src_data  = 8'h08;
    in_read   = 1'b1;
    @(negedge clk);
    check("full_no_bypass", {31'h0, src_ready}, 32'd0);
    step();
    in_read = 1'b0;
    @(negedge clk);
    check("ready_after_pop", {31'h0, src_ready}, 32'd1);
    exp_q.push_back(16'h0008);
    step();
    src_valid = 1'b0;
    for (int i = 0; i < 8; i++) read_one();

    // 4: byte, eof, then repeated -1
    push_byte(8'h41);
    src_eof = 1'b1;
    step();
    src_eof = 1'b0;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 3; i++) read_one();
    @(negedge clk);
    check("eof_in_wait", {31'h0, in_wait}, 32'd0);
    check("eof_io_in", {16'h0, io_in}, 32'h0000_FFFF);
    step();

    // 5: read held on empty FIFO, byte arrives in cycle 2
    do_reset();
    in_read = 1'b1;
    @(negedge clk);
    check("stall_c0", {31'h0, in_wait}, 32'd1);
    step();
    @(negedge clk);
    check("stall_c1", {31'h0, in_wait}, 32'd1);
    step();
    src_valid = 1'b1;
    src_data  = 8'h7A;
    @(negedge clk);
    check("stall_c2", {31'h0, in_wait}, 32'd1);
    exp_q.push_back(16'h007A);
    step();
    src_valid = 1'b0;
    @(negedge clk);
    check("stall_c3_wait", {31'h0, in_wait}, 32'd0);
    step();
    in_read = 1'b0;
    @(negedge clk);
    check("stall_popped", {28'h0, dut.u_fifo.count}, 32'd0);
    step();

    // 6: steady-state push+pop at count 3
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    for (int i = 0; i < 10; i++) begin
      src_valid = 1'b1;
      src_data  = 8'(8'hA3 + i);
      in_read   = 1'b1;
      @(negedge clk);
      check("stream_count", {28'h0, dut.u_fifo.count}, 32'd3);
      exp_q.push_back({8'h00, 8'(8'hA3 + i)});
      step();
    end
    src_valid = 1'b0;
    in_read   = 1'b0;
    for (int i = 0; i < 3; i++) read_one();

    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
